// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared FSM state codes, op codes and default width for the register bus master
package reg_bus_pkg;
   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam logic [1:0] OP_RD1   = 2'b00;
   localparam logic [1:0] OP_RD2   = 2'b01;
   localparam logic [1:0] OP_WR    = 2'b10;
   localparam logic [1:0] OP_RD2WR = 2'b11;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_A    = 3'd1;
   localparam logic [2:0] RD_B    = 3'd2;
   localparam logic [2:0] WAIT_WB = 3'd3;
   localparam logic [2:0] WR      = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;
   localparam logic [2:0] ERR     = 3'd6;
endpackage

// File: rtl/reg_bus_master_dec.sv
// reg_onehot_dec: address to one-hot strobe decoder with range flag
// Ports: en gates the strobe, addr selects the bit, onehot is the strobe vector,
// in_range is high when addr < NUM_REGS (independent of en).
module reg_onehot_dec #(
   parameter int NUM_REGS   = 6,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  en,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_REGS-1:0]   onehot,
   output logic                  in_range
);
   assign in_range = 32'(addr) < NUM_REGS;
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
      assign onehot[g] = en && addr == ADDR_WIDTH'(g);
   end
endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: sequences one-hot Load/Save strobes to read up to two registers and write one back
// Ports: clk, rst (async active-low); req/op/addr_a/addr_b/addr_w start a transaction;
// wb_valid/wdata supply writeback data; bus_in is the shared register bus;
// load/save are one-hot strobes, save_value the write data, rdata_a/rdata_b the captured reads;
// busy, done and err report transaction status.
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int NUM_REGS   = 6,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic [1:0]            op,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [ADDR_WIDTH-1:0] addr_w,
   input  logic                  wb_valid,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] bus_in,
   output logic [NUM_REGS-1:0]   load,
   output logic [NUM_REGS-1:0]   save,
   output logic [DATA_WIDTH-1:0] save_value,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   logic [2:0]            state, nxt;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] a_q, b_q, w_q;
   logic [NUM_REGS-1:0]   oh_a, oh_b, oh_w;
   logic                  ok_a, ok_b, ok_w, idle, bad;
   assign idle = state == IDLE;
   // In IDLE the decoders look at the live inputs so the range check can run
   // before acceptance; their enables are low there, so strobes never follow inputs.
   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_dec_a (
      .en(state == RD_A), .addr(idle ? addr_a : a_q), .onehot(oh_a), .in_range(ok_a));
   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_dec_b (
      .en(state == RD_B), .addr(idle ? addr_b : b_q), .onehot(oh_b), .in_range(ok_b));
   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_dec_w (
      .en(state == WR), .addr(idle ? addr_w : w_q), .onehot(oh_w), .in_range(ok_w));
   // op[0] means a second read, op[1] means a write; read A is used unless op is a pure write
   assign bad = (op != OP_WR && !ok_a) || (op[0] && !ok_b) || (op[1] && !ok_w);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !req ? IDLE : bad ? ERR : op == OP_WR ? WAIT_WB : RD_A;
         RD_A:    nxt = op_q[0] ? RD_B : DONE;
         RD_B:    nxt = op_q == OP_RD2WR ? WAIT_WB : DONE;
         WAIT_WB: nxt = wb_valid ? WR : WAIT_WB;
         WR:      nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         op_q       <= OP_RD1;
         a_q        <= '0;
         b_q        <= '0;
         w_q        <= '0;
         save_value <= '0;
         rdata_a    <= '0;
         rdata_b    <= '0;
      end else begin
         state <= nxt;
         if (idle && req) begin
            op_q <= op;
            a_q  <= addr_a;
            b_q  <= addr_b;
            w_q  <= addr_w;
         end
         if (state == RD_A) rdata_a <= bus_in;
         if (state == RD_B) rdata_b <= bus_in;
         if (state == WAIT_WB && wb_valid) save_value <= wdata;
      end
   end
   assign load = oh_a | oh_b;
   assign save = oh_w;
   assign busy = !idle;
   assign done = state == DONE || state == ERR;
   assign err  = state == ERR;
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: table-driven check of reg_bus_master against a behavioural register bank
module tb_reg_bus_master;
   import reg_bus_pkg::*;
   localparam int NR = 6;
   localparam int DW = 8;
   localparam int AW = 3;
   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] a, b, w;
      logic [DW-1:0] wd;
      int            dly;
      logic [NR-1:0] l1, l2, sv;
      int            ns, lat;
      logic          er;
      logic [DW-1:0] ra, rb;
      int            ri;
      logic [DW-1:0] rv;
   } vec_t;
   logic          clk = 0, rst = 0, req = 0, wb_valid = 0;
   logic [1:0]    op = 0;
   logic [AW-1:0] addr_a = 0, addr_b = 0, addr_w = 0;
   logic [DW-1:0] wdata = 0, bus_in, save_value, rdata_a, rdata_b;
   logic [NR-1:0] load, save;
   logic          busy, done, err;
   logic [DW-1:0] bank [0:NR-1] = '{8'h03, 8'h11, 8'h5A, 8'h00, 8'hC3, 8'h00};
   int            checks = 0, failures = 0;
   vec_t          vt [10];
   reg_bus_master #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr_a(addr_a), .addr_b(addr_b),
      .addr_w(addr_w), .wb_valid(wb_valid), .wdata(wdata), .bus_in(bus_in),
      .load(load), .save(save), .save_value(save_value), .rdata_a(rdata_a),
      .rdata_b(rdata_b), .busy(busy), .done(done), .err(err));
   always #5 clk = ~clk;
   always @(posedge clk) for (int i = 0; i < NR; i++) if (save[i]) bank[i] <= save_value;
   always_comb begin
      bus_in = '0;
      for (int i = 0; i < NR; i++) if (load[i]) bus_in = bus_in | bank[i];
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic run(input vec_t v, input string nm);
      logic [NR-1:0] la [0:3];
      logic [NR-1:0] sv = '0;
      int            ns = 0, lat = -1;
      logic          er = 0, bad = 0;
      for (int i = 0; i < 4; i++) la[i] = '0;
      @(negedge clk);
      op = v.op; addr_a = v.a; addr_b = v.b; addr_w = v.w; req = 1;
      wb_valid = v.dly == 0;
      wdata = wb_valid ? v.wd : ~v.wd;
      @(posedge clk);
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req = 0; op = ~op; addr_a = ~addr_a; addr_b = ~addr_b; addr_w = ~addr_w;
         end
         wb_valid = c >= v.dly;
         wdata = wb_valid ? v.wd : ~v.wd;
         #1;
         if (c == 1) chk({nm, " busy"}, busy, 1);
         if (c < 4) la[c] = load;
         if (save != 0) begin ns++; sv = sv | save; end
         if ($countones(load) > 1 || $countones(save) > 1 || (load != 0 && save != 0)) bad = 1;
         if (done) begin lat = c; er = err; end
      end
      wb_valid = 0;
      chk({nm, " latency"}, lat, v.lat);
      chk({nm, " err"}, er, v.er);
      chk({nm, " load1"}, la[1], v.l1);
      chk({nm, " load2"}, la[2], v.l2);
      chk({nm, " save_bits"}, sv, v.sv);
      chk({nm, " save_cycles"}, ns, v.ns);
      chk({nm, " strobe_rules"}, bad, 0);
      @(negedge clk);
      #1;
      chk({nm, " idle"}, busy, 0);
      chk({nm, " rdata_a"}, rdata_a, v.ra);
      chk({nm, " rdata_b"}, rdata_b, v.rb);
      chk({nm, " reg"}, bank[v.ri], v.rv);
      if (v.ns > 0) chk({nm, " save_value"}, save_value, v.wd);
   endtask
   initial begin
      vt[0] = '{OP_RD1,   2, 0, 0, 8'h00, 0, 6'b000100, 6'b000000, 6'b000000, 0, 2, 0, 8'h5A, 8'h00, 2, 8'h5A};
      vt[1] = '{OP_RD2,   1, 4, 0, 8'h00, 0, 6'b000010, 6'b010000, 6'b000000, 0, 3, 0, 8'h11, 8'hC3, 4, 8'hC3};
      vt[2] = '{OP_WR,    0, 0, 5, 8'h7E, 3, 6'b000000, 6'b000000, 6'b100000, 1, 5, 0, 8'h11, 8'hC3, 5, 8'h7E};
      vt[3] = '{OP_RD2WR, 0, 0, 0, 8'h06, 0, 6'b000001, 6'b000001, 6'b000001, 1, 5, 0, 8'h03, 8'h03, 0, 8'h06};
      vt[4] = '{OP_RD1,   7, 0, 0, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 1, 1, 8'h03, 8'h03, 0, 8'h06};
      vt[5] = '{OP_RD1,   3, 7, 0, 8'h00, 0, 6'b001000, 6'b000000, 6'b000000, 0, 2, 0, 8'h00, 8'h03, 3, 8'h00};
      vt[6] = '{OP_RD2,   5, 6, 0, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 1, 1, 8'h00, 8'h03, 5, 8'h7E};
      vt[7] = '{OP_WR,    0, 0, 6, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 1, 1, 8'h00, 8'h03, 0, 8'h06};
      vt[8] = '{OP_WR,    7, 7, 3, 8'hA5, 0, 6'b000000, 6'b000000, 6'b001000, 1, 3, 0, 8'h00, 8'h03, 3, 8'hA5};
      vt[9] = '{OP_RD2WR, 3, 5, 1, 8'h99, 0, 6'b001000, 6'b100000, 6'b000010, 1, 5, 0, 8'hA5, 8'h7E, 1, 8'h99};
      repeat (2) @(posedge clk);
      #1;
      chk("reset load", load, 0);
      chk("reset save", save, 0);
      chk("reset busy", busy, 0);
      chk("reset done_err", {done, err}, 0);
      chk("reset rdata", {rdata_a, rdata_b, save_value}, 0);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 10; i++) run(vt[i], $sformatf("v%0d", i));
      // reset while waiting for writeback
      @(negedge clk);
      op = OP_WR; addr_w = 2; wdata = 8'h44; wb_valid = 0; req = 1;
      @(posedge clk);
      @(negedge clk);
      req = 0;
      @(negedge clk);
      chk("wait busy", busy, 1);
      #2 rst = 0;
      #1;
      chk("wait_rst busy", busy, 0);
      chk("wait_rst strobes", {load, save}, 0);
      chk("wait_rst done", done, 0);
      chk("wait_rst rdata_a", rdata_a, 0);
      @(negedge clk);
      rst = 1;
      chk("wait_rst reg2", bank[2], 8'h5A);
      // reset while the save strobe is high
      @(negedge clk);
      op = OP_WR; addr_w = 2; wdata = 8'h44; wb_valid = 1; req = 1;
      @(posedge clk);
      @(negedge clk);
      req = 0;
      @(negedge clk);
      #1;
      chk("wr save", save, 6'b000100);
      #1 rst = 0;
      #1;
      chk("wr_rst save", save, 0);
      chk("wr_rst busy", busy, 0);
      chk("wr_rst save_value", save_value, 0);
      wb_valid = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      chk("wr_rst reg2", bank[2], 8'h5A);
      run('{OP_RD1, 2, 0, 0, 8'h00, 0, 6'b000100, 6'b000000, 6'b000000, 0, 2, 0, 8'h5A, 8'h00, 2, 8'h5A}, "after_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Bus-side controller for the register bank. It is the initiating end of the per-register Save/Load interface.
- It issues one-hot Load strobes so that exactly one register drives the shared output bus, then samples that bus.
- For writeback it drives Save_value and issues a one-hot Save strobe.
- Sits between the LEG core sequencer (req/done handshake) and the bank of register instances.

Parameters:
- NUM_REGS, 6: number of registers on the bus; valid addresses are 0..NUM_REGS-1.
- DATA_WIDTH, 8: width of the bus and data values.
- ADDR_WIDTH, 3: width of the address fields; must satisfy 2^ADDR_WIDTH >= NUM_REGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  start transaction; sampled only in IDLE.
- op  input  2  transaction type: 00 = read A; 01 = read A and B; 10 = write W; 11 = read A and B, then write W.
- addr_a  input  ADDR_WIDTH  first read address.
- addr_b  input  ADDR_WIDTH  second read address.
- addr_w  input  ADDR_WIDTH  write address.
- wb_valid  input  1  writeback data is present on wdata.
- wdata  input  DATA_WIDTH  writeback data.
- bus_in  input  DATA_WIDTH  shared register output bus.
- load  output  NUM_REGS  one-hot Load strobes, one bit per register.
- save  output  NUM_REGS  one-hot Save strobes, one bit per register.
- save_value  output  DATA_WIDTH  data driven to all registers' Save_value.
- rdata_a  output  DATA_WIDTH  captured value of read A.
- rdata_b  output  DATA_WIDTH  captured value of read B.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse: an address used by the op is >= NUM_REGS.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - load, save, save_value, rdata_a, rdata_b, busy, done and err all go to 0 immediately.
  - Applies equally mid-transaction; any strobe in progress drops immediately.
- Registered state: op and the three addresses are latched on acceptance and held for the whole transaction. Input changes after acceptance have no effect.
- Output timing: load and save are decoded from the registered state and latched addresses. They are glitch-free, contain at most one set bit each, and are never high in the same cycle.
- States: IDLE, RD_A, RD_B, WAIT_WB, WR, DONE, ERR.
- IDLE:
  - On req=1, latch op and addresses.
  - Range check covers only the addresses the op uses.
  - Any used address out of range: go to ERR.
  - Otherwise op 10 goes to WAIT_WB; all other ops go to RD_A.
- RD_A:
  - load[addr_a]=1.
  - rdata_a captures bus_in at the closing edge.
  - Next state: RD_B for op 01/11, otherwise DONE.
- RD_B:
  - load[addr_b]=1.
  - rdata_b captures bus_in at the closing edge.
  - Next state: WAIT_WB for op 11, otherwise DONE.
- WAIT_WB:
  - No strobes.
  - Stays while wb_valid=0.
  - On wb_valid=1, save_value captures wdata and the next state is WR.
- WR:
  - save[addr_w]=1 for exactly one cycle; save_value is stable throughout.
  - The target register commits at the closing edge.
  - Next state: DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 and done=1 for one cycle, no strobes, then IDLE.
- Register contents: rdata_a and rdata_b hold their last values until overwritten. Reads do not clear them.
- busy=1 in all non-IDLE states. req while busy is ignored; it is not queued.
- addr_a==addr_b is legal; two reads of the same register occur.
- addr_w equal to a read address is legal; reads complete before the write.
- Minimum latency, counted from the req edge (cycle 0) to the done cycle:
  - op 00: done in cycle 2.
  - op 01: done in cycle 3.
  - op 10: done in cycle 3 if wb_valid is already high.
  - op 11: done in cycle 5 if wb_valid is already high.
- A new req is accepted the cycle after done.

Decomposition:
- Package reg_bus_pkg holds:
  - state enum (IDLE..ERR);
  - op code constants OP_RD1, OP_RD2, OP_WR, OP_RD2WR;
  - default DATA_WIDTH.
- Sub-module reg_onehot_dec takes (en, addr) and produces a NUM_REGS-wide one-hot plus an in_range flag.
  - Three instances: read A, read B, write.
  - load is the OR of the A and B instances gated by state.

Test Plan:
- Read one: registers hold r2=0x5A; op=00, addr_a=2, req pulse → load=000100 in cycle 1 only; rdata_a=0x5A; done in cycle 2.
- Read two: r1=0x11, r4=0xC3; op=01, addr_a=1, addr_b=4 → load=000010 then 010000 in consecutive cycles; rdata_a=0x11, rdata_b=0xC3; done in cycle 3.
- Write with wait: op=10, addr_w=5; wb_valid held low for 3 cycles, then wdata=0x7E → save=100000 for exactly one cycle; save_value=0x7E; r5 reads back 0x7E.
- Read/modify/write: op=11, a=0, b=0, w=0 with r0=0x03; wb_valid=1, wdata=0x06 → rdata_a=rdata_b=0x03; then save=000001; r0=0x06; done in cycle 5.
- Error: op=00, addr_a=7 → err=1 and done=1 in cycle 1; load and save stay 0. op=00 with addr_b=7 (unused) → no err.
- Async reset in WAIT_WB, and again during WR → save drops to 0 without a clock edge; busy=0; the target register is unchanged; a new req afterwards works normally.
